// File: rtl/beat_detector.sv
// Pulse-sensor beat detector: decaying peak tracker, adaptive threshold with
// hysteresis, refractory window. Optional 4-tap moving average via FILTER_EN.
module beat_detector #(
  parameter int unsigned ADC_W           = 10,
  parameter int unsigned PEAK_INIT       = 683,
  parameter int unsigned DECAY_SHIFT     = 6,
  parameter int unsigned THRESH_MIN      = 128,
  parameter int unsigned HYST            = 16,
  parameter int unsigned REFRACT_SAMPLES = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [ADC_W-1:0] adc_measure,
  output logic             beat,
  output logic [1:0]       state,
  output logic [ADC_W-1:0] threshold,
  output logic [ADC_W-1:0] peak
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SUM_W = ADC_W + 2;
  localparam logic [ADC_W-1:0] PEAK_RST = ADC_W'(PEAK_INIT);
  localparam logic [ADC_W-1:0] TMIN     = ADC_W'(THRESH_MIN);
  localparam logic [ADC_W-1:0] HYST_V   = ADC_W'(HYST);
  localparam logic [CNT_W-1:0] REFRACT_V = CNT_W'(REFRACT_SAMPLES);

  // Threshold sits at 3/4 of the peak, clamped from below.
  function automatic logic [ADC_W-1:0] thr_of(input logic [ADC_W-1:0] p);
    logic [ADC_W-1:0] d;
    d = p - (p >> 2);
    return (d < TMIN) ? TMIN : d;
  endfunction

  localparam logic [ADC_W-1:0] THR_RST = thr_of(PEAK_RST);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RISE    = 2'b01,
    S_REFRACT = 2'b10,
    S_BAD     = 2'b11
  } state_t;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [ADC_W-1:0] x_c;
  logic [ADC_W-1:0] peak_dec_c;
  logic [ADC_W-1:0] peak_raw_c;
  logic [ADC_W-1:0] peak_nx_c;
  logic [ADC_W-1:0] lo_c;

`ifdef FILTER_EN
  // Detector sees the mean of the current sample and the three held ones.
  logic [ADC_W-1:0] tap0, tap1, tap2;
  logic [SUM_W-1:0] sum_c;

  assign sum_c = SUM_W'(adc_measure) + SUM_W'(tap0) + SUM_W'(tap1) + SUM_W'(tap2);
  assign x_c   = ADC_W'(sum_c >> 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap0 <= '0;
      tap1 <= '0;
      tap2 <= '0;
    end else if (sample_en) begin
      tap0 <= adc_measure;
      tap1 <= tap0;
      tap2 <= tap1;
    end
  end
`else
  assign x_c = adc_measure;
`endif

  assign peak_dec_c = peak - (peak >> DECAY_SHIFT);
  assign peak_raw_c = (x_c > peak) ? x_c : peak_dec_c;
  assign peak_nx_c  = (peak_raw_c < TMIN) ? TMIN : peak_raw_c;
  assign lo_c       = (threshold > HYST_V) ? (threshold - HYST_V) : '0;
  assign state      = st;

  // Tracker and FSM; comparisons use the threshold held before this sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= S_IDLE;
      beat      <= 1'b0;
      cnt       <= '0;
      peak      <= PEAK_RST;
      threshold <= THR_RST;
    end else begin
      beat <= 1'b0;
      if (sample_en) begin
        peak      <= peak_nx_c;
        threshold <= thr_of(peak_nx_c);
      end
      if (st == S_BAD) begin
        st  <= S_IDLE;
        cnt <= '0;
      end else if (sample_en) begin
        case (st)
          S_IDLE: begin
            if (x_c >= threshold) begin
              st   <= S_RISE;
              beat <= 1'b1;
            end
          end
          S_RISE: begin
            if (x_c < lo_c) begin
              st  <= S_REFRACT;
              cnt <= REFRACT_V;
            end
          end
          S_REFRACT: begin
            // Last refractory sample returns to IDLE without a beat check.
            if (cnt <= CNT_W'(1)) begin
              st  <= S_IDLE;
              cnt <= '0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_beat_detector.sv
// Directed bench for beat_detector (default build, raw samples).
module tb_beat_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_en = 1'b0;
  logic [9:0] adc_measure = '0;
  logic       beat;
  logic [1:0] state;
  logic [9:0] threshold;
  logic [9:0] peak;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int adc;
    int st;
    int bt;
    int pk;
    int th;
  } vec_t;

  vec_t decay_v[20];
  vec_t edge_v[4];

  beat_detector dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .adc_measure(adc_measure),
    .beat       (beat),
    .state      (state),
    .threshold  (threshold),
    .peak       (peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input int st, input int bt, input int pk, input int th);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".beat"}, int'(beat), bt);
    chk({tag, ".peak"}, int'(peak), pk);
    chk({tag, ".threshold"}, int'(threshold), th);
  endtask

  // One sample strobe; returns at the following negedge with outputs settled.
  task automatic samp(input int v);
    adc_measure = 10'(v);
    sample_en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_en   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    decay_v[0]  = '{300, 0, 0, 673, 505};
    decay_v[1]  = '{300, 0, 0, 663, 498};
    decay_v[2]  = '{300, 0, 0, 653, 490};
    decay_v[3]  = '{300, 0, 0, 643, 483};
    decay_v[4]  = '{300, 0, 0, 633, 475};
    decay_v[5]  = '{300, 0, 0, 624, 468};
    decay_v[6]  = '{300, 0, 0, 615, 462};
    decay_v[7]  = '{300, 0, 0, 606, 455};
    decay_v[8]  = '{300, 0, 0, 597, 448};
    decay_v[9]  = '{300, 0, 0, 588, 441};
    decay_v[10] = '{300, 0, 0, 579, 435};
    decay_v[11] = '{300, 0, 0, 570, 428};
    decay_v[12] = '{300, 0, 0, 562, 422};
    decay_v[13] = '{300, 0, 0, 554, 416};
    decay_v[14] = '{300, 0, 0, 546, 410};
    decay_v[15] = '{300, 0, 0, 538, 404};
    decay_v[16] = '{300, 0, 0, 530, 398};
    decay_v[17] = '{300, 0, 0, 522, 392};
    decay_v[18] = '{300, 0, 0, 514, 386};
    decay_v[19] = '{300, 0, 0, 506, 380};

    // Threshold equality fires; sample equal to exit level keeps RISE.
    edge_v[0] = '{512, 0, 0, 673, 505};
    edge_v[1] = '{505, 1, 1, 663, 498};
    edge_v[2] = '{482, 1, 0, 653, 490};
    edge_v[3] = '{473, 2, 0, 643, 483};

    // Reset state while held and after idle clocks.
    #12;
    chk_all("in_reset", 0, 0, 683, 513);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk_all("post_reset", 0, 0, 683, 513);

    // Sub-threshold samples spaced every 4 clk: pure decay, never a beat.
    for (int i = 0; i < 20; i++) begin
      samp(decay_v[i].adc);
      chk_all($sformatf("decay[%0d]", i), decay_v[i].st, decay_v[i].bt, decay_v[i].pk, decay_v[i].th);
      repeat (3) @(negedge clk);
    end

    // Single beat and its one-clock pulse.
    do_reset();
    samp(900);
    chk_all("beat900", 1, 1, 900, 675);
    @(negedge clk);
    chk("beat_clear.beat", int'(beat), 0);
    chk("beat_clear.state", int'(state), 1);
    samp(200);
    chk_all("to_refract", 2, 0, 886, 665);

    // Refractory window on back-to-back samples.
    for (int k = 1; k <= 50; k++) begin
      samp((k == 10 || k == 50) ? 900 : 200);
      if (k == 10) chk_all("refract_k10", 2, 0, 900, 675);
      if (k == 49) chk("refract_k49.state", int'(state), 2);
      if (k == 50) chk_all("refract_end", 0, 0, 900, 675);
    end
    samp(900);
    chk_all("rebeat", 1, 1, 886, 665);

    // Asynchronous reset while the beat pulse is high.
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 683, 513);
    @(negedge clk);
    rst = 1'b1;

    // Threshold and hysteresis boundaries.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      samp(edge_v[i].adc);
      chk_all($sformatf("edge[%0d]", i), edge_v[i].st, edge_v[i].bt, edge_v[i].pk, edge_v[i].th);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
